vp_spm_arb: RTL and testbench

- Arbiter and sequencer for the single shared scratchpad (SPM) port.
- Shares the port between NUM_REQ requesters: requester 0 = vector processor load/store path, requester 1 = host/DMA preload path.
- Read and write channels are arbitrated independently, with round-robin fairness and burst locking.
- Read data returns after the fixed SPM read latency and is routed back to the requester that issued the read.

---
 rtl/vp_spm_pkg.sv | 31 +++
 rtl/vp_spm_rr_lock.sv | 76 +++++++
 rtl/vp_spm_arb.sv | 101 ++++++++++
 tb/tb_vp_spm_arb.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_spm_pkg.sv
// Shared types and helpers for the scratchpad port arbiter.
// Holds the round-robin select function, lock-state enum and requester indices.
package vp_spm_pkg;

  localparam int unsigned MAX_REQ = 4;

  localparam int unsigned REQ_VP  = 0;
  localparam int unsigned REQ_DMA = 1;

  typedef enum logic {IDLE, LOCKED} lock_state_e;

  // One-hot of the first set request at or after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_select(input logic [MAX_REQ-1:0] req,
                                                   input int unsigned ptr,
                                                   input int unsigned n);
    logic [MAX_REQ-1:0] sel;
    logic               found;
    int unsigned        idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = (ptr + i) % n;
      if (!found && (i < n) && req[idx[1:0]]) begin
        sel[idx[1:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/vp_spm_rr_lock.sv
// One channel of the SPM arbiter: round-robin pointer, burst lock and grant.
// Grants are combinational from req; state advances on the granted beat.
module vp_spm_rr_lock
  import vp_spm_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  lock_state_e        state_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   ptr_nxt;
  logic [MAX_REQ-1:0] req_pad;
  logic [MAX_REQ-1:0] sel;
  logic               sel_any;

  always_comb begin
    req_pad                = '0;
    req_pad[NUM_REQ-1:0]   = req;
    sel                    = rr_select(req_pad, 32'(ptr_q), NUM_REQ);
    sel_any                = |sel;
    gnt                    = '0;
    gnt_idx                = owner_q;
    if (!rst) begin
      if (state_q == IDLE) begin
        if (sel_any) begin
          gnt = sel[NUM_REQ-1:0];
          for (int i = 0; i < NUM_REQ; i++) begin
            if (sel[i]) gnt_idx = IDX_W'(i);
          end
        end
      end else if (req[owner_q]) begin
        gnt[owner_q] = 1'b1;
      end
    end
    ptr_nxt = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= IDX_W'(REQ_VP);
      ptr_q   <= IDX_W'(REQ_VP);
    end else begin
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            if (last[gnt_idx]) begin
              ptr_q <= ptr_nxt;
            end else begin
              state_q <= LOCKED;
              owner_q <= gnt_idx;
            end
          end
        end
        LOCKED: begin
          // A missing request is a bubble; the lock is only released by a last beat.
          if (|gnt && last[owner_q]) begin
            state_q <= IDLE;
            ptr_q   <= ptr_nxt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/vp_spm_arb.sv
// Shared scratchpad port arbiter: independent read/write round-robin channels with
// burst locking, zero-latency SPM muxing and a read-tag pipeline for data return.
module vp_spm_arb
  import vp_spm_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        i_rd_req,
  input  logic [NUM_REQ-1:0]        i_rd_last,
  input  logic [NUM_REQ*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_REQ-1:0]        o_rd_gnt,
  output logic [NUM_REQ-1:0]        o_rd_vld,
  output logic [DATA_W-1:0]         o_rd_data,
  input  logic [NUM_REQ-1:0]        i_wr_req,
  input  logic [NUM_REQ-1:0]        i_wr_last,
  input  logic [NUM_REQ*ADDR_W-1:0] i_wr_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_wr_data,
  output logic [NUM_REQ-1:0]        o_wr_gnt,
  output logic                      o_spm_rden,
  output logic [ADDR_W-1:0]         o_spm_rdaddr,
  input  logic [DATA_W-1:0]         i_spm_rdata,
  output logic                      o_spm_wren,
  output logic [ADDR_W-1:0]         o_spm_wraddr,
  output logic [DATA_W-1:0]         o_spm_wdata
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;

  logic             tag_vld_q [RD_LAT];
  logic [IDX_W-1:0] tag_idx_q [RD_LAT];

  vp_spm_rr_lock #(
    .NUM_REQ (NUM_REQ)
  ) u_rd_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (i_rd_req),
    .last    (i_rd_last),
    .gnt     (o_rd_gnt),
    .gnt_idx (rd_idx)
  );

  vp_spm_rr_lock #(
    .NUM_REQ (NUM_REQ)
  ) u_wr_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (i_wr_req),
    .last    (i_wr_last),
    .gnt     (o_wr_gnt),
    .gnt_idx (wr_idx)
  );

  always_comb begin
    o_spm_rden   = |o_rd_gnt;
    o_spm_wren   = |o_wr_gnt;
    o_spm_rdaddr = '0;
    o_spm_wraddr = '0;
    o_spm_wdata  = '0;
    if (o_spm_rden) o_spm_rdaddr = i_rd_addr[rd_idx*ADDR_W +: ADDR_W];
    if (o_spm_wren) begin
      o_spm_wraddr = i_wr_addr[wr_idx*ADDR_W +: ADDR_W];
      o_spm_wdata  = i_wr_data[wr_idx*DATA_W +: DATA_W];
    end
  end

  // Tags travel alongside the SPM read latency so data is steered to its issuer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_vld_q[i] <= 1'b0;
        tag_idx_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0] <= o_spm_rden;
      tag_idx_q[0] <= rd_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  always_comb begin
    o_rd_vld  = '0;
    o_rd_data = '0;
    if (!rst && tag_vld_q[RD_LAT-1]) begin
      o_rd_vld[tag_idx_q[RD_LAT-1]] = 1'b1;
      o_rd_data                     = i_spm_rdata;
    end
  end

endmodule

// File: tb/tb_vp_spm_arb.sv
// Directed bench for vp_spm_arb with a two-cycle SPM read model whose data
// pattern is the read address replicated across the word.
module tb_vp_spm_arb;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    rd_req, rd_last, rd_gnt, rd_vld;
  logic [31:0]   rd_addr;
  logic [511:0]  rd_data;
  logic [1:0]    wr_req, wr_last, wr_gnt;
  logic [31:0]   wr_addr;
  logic [1023:0] wr_data;
  logic          spm_rden, spm_wren;
  logic [15:0]   spm_rdaddr, spm_wraddr;
  logic [511:0]  spm_rdata, spm_wdata;
  logic [511:0]  spm_p1 = '0;
  logic [511:0]  spm_p2 = '0;

  int n_asserts = 0;
  int n_fail    = 0;

  localparam logic [511:0] DMA_D = {16{32'hD0A0_0200}};
  localparam logic [511:0] A5_D  = {64{8'hA5}};

  always #5 clk = ~clk;

  vp_spm_arb u_dut (
    .clk          (clk),
    .rst          (rst),
    .i_rd_req     (rd_req),
    .i_rd_last    (rd_last),
    .i_rd_addr    (rd_addr),
    .o_rd_gnt     (rd_gnt),
    .o_rd_vld     (rd_vld),
    .o_rd_data    (rd_data),
    .i_wr_req     (wr_req),
    .i_wr_last    (wr_last),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
    .o_wr_gnt     (wr_gnt),
    .o_spm_rden   (spm_rden),
    .o_spm_rdaddr (spm_rdaddr),
    .i_spm_rdata  (spm_rdata),
    .o_spm_wren   (spm_wren),
    .o_spm_wraddr (spm_wraddr),
    .o_spm_wdata  (spm_wdata)
  );

  function automatic logic [511:0] pat(input logic [15:0] a);
    return {32{a}};
  endfunction

  always @(posedge clk) begin
    spm_p1 <= spm_rden ? pat(spm_rdaddr) : '0;
    spm_p2 <= spm_p1;
  end
  assign spm_rdata = spm_p2;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rd_req  = '0;
    rd_last = '0;
    wr_req  = '0;
    wr_last = '0;
  endtask

  initial begin
    logic [1:0]  eg;
    logic [15:0] ea;
    rst     = 1'b1;
    clr();
    rd_req  = 2'b11;
    rd_last = 2'b11;
    rd_addr = {16'h20, 16'h10};
    wr_addr = '0;
    wr_data = '0;
    cyc();
    #4;
    chk("reset_outputs", {rd_gnt, wr_gnt, rd_vld, spm_rden, spm_wren, spm_rdaddr}, '0);

    // Alternating single-beat reads.
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      eg = (i % 2 == 0) ? 2'b01 : 2'b10;
      ea = (i % 2 == 0) ? 16'h10 : 16'h20;
      #4;
      chk("rr_rd_gnt", rd_gnt, eg);
      chk("rr_rdaddr", spm_rdaddr, ea);
      if (i >= 2) begin
        chk("rr_rd_vld", rd_vld, eg);
        chk("rr_rd_data", rd_data, pat(ea));
      end else begin
        chk("rr_rd_vld_early", rd_vld, 2'b00);
      end
      cyc();
    end
    clr();
    #4;
    chk("drain_vld0", rd_vld, 2'b01);
    chk("drain_data0", rd_data, pat(16'h10));
    cyc();
    #4;
    chk("drain_vld1", rd_vld, 2'b10);
    cyc();

    // Idle: nothing asserted, pointer unchanged (still at VP).
    for (int i = 0; i < 10; i++) begin
      #4;
      chk("idle_outputs", {rd_gnt, wr_gnt, rd_vld, spm_rden, spm_wren}, '0);
      cyc();
    end
    rd_req  = 2'b11;
    rd_last = 2'b11;
    #4;
    chk("idle_ptr_kept", rd_gnt, 2'b01);
    cyc();
    clr();
    cyc();
    #4;
    chk("idle_read_ret", rd_vld, 2'b01);
    cyc();

    // VP 4-beat write burst; DMA requests from the second beat.
    wr_req  = 2'b01;
    wr_last = 2'b00;
    wr_addr = {16'h200, 16'h100};
    wr_data = {DMA_D, pat(16'h100)};
    #4;
    chk("wb_gnt0", wr_gnt, 2'b01);
    chk("wb_addr0", {spm_wren, spm_wraddr}, {1'b1, 16'h100});
    chk("wb_data0", spm_wdata, pat(16'h100));
    cyc();
    for (int i = 1; i < 4; i++) begin
      wr_req  = 2'b11;
      wr_last = (i == 3) ? 2'b11 : 2'b10;
      wr_addr = {16'h200, 16'h100 + 16'(i)};
      wr_data = {DMA_D, pat(16'h100 + 16'(i))};
      #4;
      chk("wb_locked_gnt", wr_gnt, 2'b01);
      chk("wb_locked_addr", spm_wraddr, 16'h100 + 16'(i));
      cyc();
    end
    wr_addr = {16'h200, 16'h104};
    wr_data = {DMA_D, pat(16'h104)};
    #4;
    chk("wb_dma_gnt", wr_gnt, 2'b10);
    chk("wb_dma_addr", spm_wraddr, 16'h200);
    chk("wb_dma_data", spm_wdata, DMA_D);
    cyc();
    wr_req = 2'b01;
    #4;
    chk("wb_vp_next", wr_gnt, 2'b01);
    chk("wb_vp_next_addr", spm_wraddr, 16'h104);
    cyc();
    clr();
    cyc();

    // VP read burst with a 3-cycle bubble; DMA must not preempt.
    rd_req  = 2'b01;
    rd_last = 2'b00;
    rd_addr = {16'h20, 16'h300};
    #4;
    chk("rb_gnt0", rd_gnt, 2'b01);
    chk("rb_addr0", spm_rdaddr, 16'h300);
    cyc();
    rd_req  = 2'b11;
    rd_last = 2'b10;
    rd_addr = {16'h20, 16'h301};
    #4;
    chk("rb_gnt1", rd_gnt, 2'b01);
    cyc();
    rd_req = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("rb_bubble", {rd_gnt, spm_rden}, 3'b000);
      cyc();
    end
    rd_req  = 2'b11;
    rd_last = 2'b11;
    rd_addr = {16'h20, 16'h302};
    #4;
    chk("rb_resume_gnt", rd_gnt, 2'b01);
    chk("rb_resume_addr", spm_rdaddr, 16'h302);
    cyc();
    rd_req = 2'b10;
    #4;
    chk("rb_dma_after", rd_gnt, 2'b10);
    chk("rb_dma_addr", spm_rdaddr, 16'h20);
    cyc();
    clr();
    cyc();

    // Same-cycle read and write to the same address from different requesters.
    rd_req  = 2'b01;
    rd_last = 2'b11;
    rd_addr = {16'h20, 16'h40};
    wr_req  = 2'b10;
    wr_last = 2'b11;
    wr_addr = {16'h40, 16'h0};
    wr_data = {A5_D, 512'h0};
    #4;
    chk("sim_gnts", {rd_gnt, wr_gnt}, 4'b0110);
    chk("sim_en", {spm_rden, spm_wren}, 2'b11);
    chk("sim_addrs", {spm_rdaddr, spm_wraddr}, {16'h40, 16'h40});
    chk("sim_wdata", spm_wdata, A5_D);
    cyc();
    clr();
    cyc();

    // Reset one cycle after a granted read: its return is discarded.
    rd_req  = 2'b01;
    rd_last = 2'b11;
    rd_addr = {16'h20, 16'h50};
    #4;
    chk("rst_pre_gnt", rd_gnt, 2'b01);
    cyc();
    clr();
    rst = 1'b1;
    #4;
    chk("rst_during", {rd_vld, rd_gnt, spm_rden}, '0);
    cyc();
    rst = 1'b0;
    #4;
    chk("rst_vld_discard", rd_vld, 2'b00);
    cyc();
    rd_req  = 2'b11;
    rd_last = 2'b11;
    rd_addr = {16'h20, 16'h10};
    #4;
    chk("rst_vld_still0", rd_vld, 2'b00);
    chk("rst_ptr_vp", rd_gnt, 2'b01);
    cyc();
    clr();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
